hpdmc_ddr_wrpath: RTL
=====================

# hpdmc_ddr_wrpath

Parametrised DDR write-path output stage for the HPDMC controller: it buffers write beats in a small FIFO, sequences a DQS preamble/burst/postamble, and presents registered rising/falling-edge words (DQ, DM, DQS) plus output enables to per-bit DDR output register cells. It generalises the fixed 4-bit DDR output wrapper to any DQ width with byte masks, strobe generation, burst sequencing and underrun handling.

## Interface
- DQ_WIDTH, 16, DQ bits; multiple of 8; DM width is DQ_WIDTH/8.
- BURST_CYCLES, 2, clock cycles per burst, two beats each; legal range 1..8.
- FIFO_DEPTH, 4, write-beat FIFO entries; power of 2, at least 2.
- INIT, 1'b0, idle value replicated onto every DQ bit.

- sys_clk  in  1  controller clock; all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  write beat-pair offered.
- in_ready  out  1  FIFO not full; push when in_valid & in_ready.
- in_d1 / in_d2  in  DQ_WIDTH  rising / falling beat data.
- in_m1 / in_m2  in  DQ_WIDTH/8  rising / falling byte masks; 1 = masked.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held.
- wr_start  in  1  start a burst; sampled only in IDLE or POST.
- wr_busy  out  1  FSM not in IDLE.
- wr_done  out  1  one-cycle pulse during POST.
- underrun  out  1  sticky; a BURST cycle found the FIFO empty.
- underrun_clr  in  1  clears underrun.
- dq_d1 / dq_d2  out  DQ_WIDTH  registered DQ halves to DDR cells.
- dm_d1 / dm_d2  out  DQ_WIDTH/8  registered DM halves.
- dqs_d1 / dqs_d2  out  1  registered DQS halves.
- dq_oe / dqs_oe  out  1  registered drive enables.

## Operation
- FIFO: entry = {d1,d2,m1,m2}; push on in_valid & in_ready; pop once per BURST cycle when non-empty. in_ready = !full, so full-and-push never occurs; simultaneous push and pop in one cycle keeps fifo_level unchanged.
- FSM states IDLE, PRE, BURST, POST.
  - IDLE: wr_start -> PRE; otherwise stay.
  - PRE (1 cycle) -> BURST.
  - BURST: cycle counter 0..BURST_CYCLES-1; at last count -> POST.
  - POST (1 cycle): wr_start -> PRE (back-to-back, DQS drive kept); else -> IDLE.
  - wr_start in PRE/BURST is ignored.
- Output values while in each state (registered, computed from the next state):
  - IDLE: dq = {INIT}, dm = 0, dqs = 0/0, dq_oe = 0, dqs_oe = 0.
  - PRE: dqs = 0/0, dqs_oe = 1, dq_oe = 0, dq = {INIT}.
  - BURST: dqs_d1 = 1, dqs_d2 = 0, dqs_oe = 1, dq_oe = 1; dq/dm = popped entry. If FIFO empty: dq = {INIT}, dm = all ones, underrun set, no pop.
  - POST: dqs = 0/0, dqs_oe = 1, dq_oe = 0, wr_done = 1.
- underrun: set has priority over underrun_clr in the same cycle.
- Reset (async, sys_rst_n low): FSM IDLE, counter 0, FIFO empty, fifo_level 0, in_ready 1, all outputs at IDLE values, wr_busy/wr_done/underrun 0. Reset mid-burst aborts it; buffered data is discarded.

## Timing
- wr_start high at edge k: PRE values visible after edge k; first data after edge k+1; last data after edge k+BURST_CYCLES; POST with wr_done after edge k+BURST_CYCLES+1; IDLE after edge k+BURST_CYCLES+2.
- wr_busy is high from after edge k through the POST cycle.
- Back-to-back bursts: one POST plus one PRE cycle between bursts; dqs_oe never drops.
- Beat pushed at edge j can be popped no earlier than the BURST cycle following edge j+1.
- fifo_level and in_ready update on the edge of the push or pop.

## Test plan
- Reset: hold sys_rst_n low mid-BURST -> all outputs immediately at IDLE values, fifo_level = 0, in_ready = 1, underrun = 0.
- Single burst, defaults: push pairs A/B = 16'h1111/16'h2222 and 16'h3333/16'h4444 with masks 0, then wr_start -> PRE, then two BURST cycles with dq_d1/dq_d2 = 1111/2222 then 3333/4444, then POST with wr_done = 1, then IDLE; 4 cycles total.
- Underrun: push one entry, BURST_CYCLES = 2, wr_start -> second BURST cycle shows dq = 0, dm = 2'b11, underrun = 1; underrun_clr sets it back to 0, except when asserted during an underrunning cycle.
- Full FIFO: push 4 entries with no burst -> in_ready = 0, fifo_level = 4, a 5th offer is not accepted; a burst pops and in_ready returns to 1.
- Back-to-back: wr_start held through POST -> POST then PRE then BURST with dqs_oe continuously 1 and two wr_done pulses.
- Parameter sweep: DQ_WIDTH = 32, BURST_CYCLES = 4, FIFO_DEPTH = 8, INIT = 1 -> idle dq = 32'hFFFFFFFF, DM width 4, 4 BURST cycles per burst.

Source files
------------

// File: rtl/hpdmc_ddr_wrpath.sv
// DDR write-path output stage: beat FIFO, DQS preamble/burst/postamble sequencing,
// and registered rise/fall words plus drive enables for the DDR output cells.
//
// state   | meaning
// S_IDLE  | bus released, DQ at idle level, waiting for wr_start
// S_PRE   | DQS preamble: strobe driven low, DQ not driven
// S_BURST | one beat pair per cycle from the FIFO, DQS toggling
// S_POST  | DQS postamble, wr_done pulse; wr_start chains another burst
module hpdmc_ddr_wrpath #(
  parameter int   DQ_WIDTH     = 16,
  parameter int   BURST_CYCLES = 2,
  parameter int   FIFO_DEPTH   = 4,
  parameter logic INIT         = 1'b0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DQ_WIDTH-1:0]           in_d1,
  input  logic [DQ_WIDTH-1:0]           in_d2,
  input  logic [DQ_WIDTH/8-1:0]         in_m1,
  input  logic [DQ_WIDTH/8-1:0]         in_m2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          wr_start,
  output logic                          wr_busy,
  output logic                          wr_done,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [DQ_WIDTH-1:0]           dq_d1,
  output logic [DQ_WIDTH-1:0]           dq_d2,
  output logic [DQ_WIDTH/8-1:0]         dm_d1,
  output logic [DQ_WIDTH/8-1:0]         dm_d2,
  output logic                          dqs_d1,
  output logic                          dqs_d2,
  output logic                          dq_oe,
  output logic                          dqs_oe
);

  localparam int DMW = DQ_WIDTH / 8;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = 2 * DQ_WIDTH + 2 * DMW;
  localparam int CW  = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;

  localparam logic [LW-1:0]       LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0]       CNT_LOAD = CW'(BURST_CYCLES - 1);
  localparam logic [DQ_WIDTH-1:0] DQ_IDLE  = {DQ_WIDTH{INIT}};

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_BURST, S_POST} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count;
  logic                fifo_empty, push, pop, starve;
  logic [DQ_WIDTH-1:0] ent_d1, ent_d2;
  logic [DMW-1:0]      ent_m1, ent_m2;

  logic [DQ_WIDTH-1:0] dq_d1_nxt, dq_d2_nxt;
  logic [DMW-1:0]      dm_d1_nxt, dm_d2_nxt;
  logic                dqs_d1_nxt, dqs_d2_nxt, dq_oe_nxt, dqs_oe_nxt;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != LVL_FULL);
  assign fifo_level = count;
  assign push       = in_valid & in_ready;
  // Outputs are registered from the next state, so the pop happens on the edge entering each BURST cycle.
  assign pop        = (state_nxt == S_BURST) & ~fifo_empty;
  assign starve     = (state_nxt == S_BURST) & fifo_empty;
  assign {ent_d1, ent_d2, ent_m1, ent_m2} = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {in_d1, in_d2, in_m1, in_m2};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (wr_start) state_nxt = S_PRE;
      S_PRE:   state_nxt = S_BURST;
      S_BURST: if (cnt == '0) state_nxt = S_POST;
      S_POST:  state_nxt = wr_start ? S_PRE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Beat counter runs down from BURST_CYCLES-1; zero marks the last BURST cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                         cnt <= '0;
    else if (state == S_PRE)                cnt <= CNT_LOAD;
    else if (state == S_BURST && cnt != '0) cnt <= cnt - CW'(1);
  end

  always_comb begin
    dq_d1_nxt  = DQ_IDLE;
    dq_d2_nxt  = DQ_IDLE;
    dm_d1_nxt  = '0;
    dm_d2_nxt  = '0;
    dqs_d1_nxt = 1'b0;
    dqs_d2_nxt = 1'b0;
    dq_oe_nxt  = 1'b0;
    dqs_oe_nxt = 1'b0;
    case (state_nxt)
      S_PRE, S_POST: dqs_oe_nxt = 1'b1;
      S_BURST: begin
        dqs_d1_nxt = 1'b1;
        dq_oe_nxt  = 1'b1;
        dqs_oe_nxt = 1'b1;
        if (fifo_empty) begin
          dm_d1_nxt = '1;
          dm_d2_nxt = '1;
        end else begin
          dq_d1_nxt = ent_d1;
          dq_d2_nxt = ent_d2;
          dm_d1_nxt = ent_m1;
          dm_d2_nxt = ent_m2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dq_d1  <= DQ_IDLE;
      dq_d2  <= DQ_IDLE;
      dm_d1  <= '0;
      dm_d2  <= '0;
      dqs_d1 <= 1'b0;
      dqs_d2 <= 1'b0;
      dq_oe  <= 1'b0;
      dqs_oe <= 1'b0;
    end else begin
      dq_d1  <= dq_d1_nxt;
      dq_d2  <= dq_d2_nxt;
      dm_d1  <= dm_d1_nxt;
      dm_d2  <= dm_d2_nxt;
      dqs_d1 <= dqs_d1_nxt;
      dqs_d2 <= dqs_d2_nxt;
      dq_oe  <= dq_oe_nxt;
      dqs_oe <= dqs_oe_nxt;
    end
  end

  // A starved BURST cycle wins over a simultaneous clear so the event is never lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)        underrun <= 1'b0;
    else if (starve)       underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

  assign wr_busy = (state != S_IDLE);
  assign wr_done = (state == S_POST);

endmodule
